// File: rtl/if_stage.sv
// Instruction-fetch stage: assembles each 32-bit instruction from four byte reads
// on the 8-bit memory port, and holds it for IF/ID until the PC may advance.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_addr_i,
  input  logic [7:0]  mem_data_i,
  input  logic        mem_valid_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_o
);

  typedef enum logic [2:0] {
    B0   = 3'd0,
    B1   = 3'd1,
    B2   = 3'd2,
    B3   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [1:0]  byte_sel;
  logic        fetching;

  // Only stall[0] concerns this stage; the rest of the vector is for later stages.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  always_comb begin
    byte_sel = 2'd0;
    case (state_q)
      B1:      byte_sel = 2'd1;
      B2:      byte_sel = 2'd2;
      B3:      byte_sel = 2'd3;
      default: byte_sel = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    if (branch_flag_i) begin
      // Redirect wins over stall and discards any byte arriving this cycle.
      pc_d    = branch_target_addr_i;
      buf_d   = '0;
      state_d = B0;
    end else begin
      case (state_q)
        DONE: begin
          if (!stall[0]) begin
            pc_d    = pc_q + 32'd4;
            buf_d   = '0;
            state_d = B0;
          end
        end
        default: begin
          if (mem_valid_i) begin
            buf_d[{byte_sel, 3'b000} +: 8] = mem_data_i;
            case (state_q)
              B0:      state_d = B1;
              B1:      state_d = B2;
              B2:      state_d = B3;
              default: state_d = DONE;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= B0;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  assign fetching   = (state_q != DONE);
  assign mem_req_o  = fetching && !rst;
  assign stallreq_o = fetching && !rst;
  assign mem_addr_o = pc_q + {30'd0, byte_sel};
  assign if_pc      = pc_q;
  assign if_inst    = (!rst && state_q == DONE) ? buf_q : '0;

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage: memory contents are a hash of the address,
// and the model predicts which PC each completed fetch must carry.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_addr_i;
  logic [7:0]  mem_data_i;
  logic        mem_valid_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_o;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .stall                (stall),
    .branch_flag_i        (branch_flag_i),
    .branch_target_addr_i (branch_target_addr_i),
    .mem_data_i           (mem_data_i),
    .mem_valid_i          (mem_valid_i),
    .mem_req_o            (mem_req_o),
    .mem_addr_o           (mem_addr_o),
    .if_pc                (if_pc),
    .if_inst              (if_inst),
    .stallreq_o           (stallreq_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_done   = 0;
  logic [31:0] exp_q[$];
  bit          zw = 1'b0;

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h9E37_79B1;
    return h[31:24] ^ h[11:4];
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mbyte(a + 32'd3), mbyte(a + 32'd2), mbyte(a + 32'd1), mbyte(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; percentages for wait states, stall, branch and reset.
  task automatic cycle(input int unsigned pw, input int unsigned ps,
                       input int unsigned pb, input int unsigned pr);
    logic [5:0]  s;
    logic [31:0] tgt;
    bit          do_rst;
    bit          do_br;
    do_rst = ($urandom_range(99) < pr);
    do_br  = ($urandom_range(99) < pb);
    s      = 6'($urandom);
    s[0]   = ($urandom_range(99) < ps);
    if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(15));
    else                        tgt = $urandom;
    rst                  = do_rst;
    stall                = s;
    branch_flag_i        = do_br;
    branch_target_addr_i = tgt;
    mem_valid_i          = ($urandom_range(99) >= pw);
    mem_data_i           = mbyte(mem_addr_o);
    @(posedge clk);
    #1;
    if (do_rst) begin
      exp_q.delete();
      exp_q.push_back(RST_PC);
    end else if (do_br) begin
      exp_q.delete();
      exp_q.push_back(tgt);
    end
  endtask

  // Monitor: a completed instruction is the first cycle stallreq_o is low after a fetch.
  bit          prev_hi = 1'b0;
  bit          held_valid = 1'b0;
  bit          zw_last = 1'b0;
  logic [31:0] held_pc, held_inst;
  int unsigned cyc = 0, last_done = 0, idle = 0;

  always @(negedge clk) begin
    logic [31:0] e;
    cyc++;
    if (rst) begin
      chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
      chk("rst_stallreq", {31'd0, stallreq_o}, 32'd0);
      chk("rst_if_inst", if_inst, 32'd0);
      prev_hi = 1'b0;
      held_valid = 1'b0;
      zw_last = 1'b0;
      idle = 0;
    end else begin
      chk("req_eq_stallreq", {31'd0, mem_req_o}, {31'd0, stallreq_o});
      if (!stallreq_o) begin
        idle = 0;
        if (prev_hi) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got pc %h expected none", if_pc);
          end else begin
            e = exp_q.pop_front();
            exp_q.push_back(e + 32'd4);
            chk("done_pc", if_pc, e);
            chk("done_inst", if_inst, word_at(e));
            if (zw && zw_last) chk("zero_wait_spacing", cyc - last_done, 32'd5);
            zw_last = zw;
            last_done = cyc;
            held_pc = e;
            held_inst = word_at(e);
            held_valid = 1'b1;
            n_done++;
          end
        end else if (held_valid) begin
          chk("hold_pc", if_pc, held_pc);
          chk("hold_inst", if_inst, held_inst);
        end
      end else begin
        held_valid = 1'b0;
        chk("fetch_inst_zero", if_inst, 32'd0);
        if (exp_q.size() != 0) begin
          chk("fetch_pc", if_pc, exp_q[0]);
          chk("addr_in_word", {31'd0, (mem_addr_o - exp_q[0]) < 32'd4}, 32'd1);
        end
        idle++;
        if (idle > 400) begin
          n_checks++;
          n_fail++;
          $display("FAIL fetch_timeout: got %0d cycles expected at most 400", idle);
          idle = 0;
        end
      end
      prev_hi = stallreq_o;
    end
  end

  initial begin
    rst = 1'b1;
    stall = '0;
    branch_flag_i = 1'b0;
    branch_target_addr_i = '0;
    mem_valid_i = 1'b0;
    mem_data_i = '0;
    @(posedge clk);
    #1;
    exp_q.push_back(RST_PC);
    zw = 1'b1;
    repeat (60)   cycle(0, 0, 0, 0);
    zw = 1'b0;
    repeat (600)  cycle(60, 50, 0, 0);
    repeat (2000) cycle(30, 30, 8, 0);
    repeat (1500) cycle(40, 40, 5, 1);
    repeat (10)   cycle(0, 0, 0, 0);
    zw = 1'b1;
    repeat (60)   cycle(0, 0, 0, 0);
    zw = 1'b0;
    repeat (5)    cycle(0, 100, 0, 0);
    chk("completions_seen", {31'd0, n_done >= 100}, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
